mmu_rsp_arbiter: RTL and testbench
==================================

# mmu_rsp_arbiter

Downstream stage of the MMU core: captures the core's two fire-and-forget response strobes (alloc and free), buffers each in a small FIFO, and merges them into one valid/ready response stream toward the host interface. The core never checks for back-pressure, so this block absorbs bursts, arbitrates fairly, and flags any response it had to drop.

## Interface
Parameters:
- DEPTH, 8, entries per channel FIFO; power of two, ≥2
- PTR_W, 3, log2(DEPTH)
- ID_W, `REQ_ID_WIDTH, request id width
- IDX_W, `ALL_PAGE_IDX_WIDTH, page index width (512 B units)
- FR_W, `FAIL_REASON_WIDTH, fail reason width
- AFULL_LVL, 6, occupancy at or above which `*_afull` asserts

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- alloc_rsp_write_en  in  1  alloc response strobe, one entry per high cycle
- alloc_rsp_id  in  ID_W  alloc id
- alloc_rsp_page_idx  in  IDX_W  allocated page index
- alloc_rsp_fail  in  1  alloc failed
- alloc_rsp_fail_reason  in  FR_W  alloc fail reason
- free_rsp_write_en  in  1  free response strobe
- free_rsp_id  in  ID_W  free id
- free_rsp_fail  in  1  free failed
- free_rsp_fail_reason  in  FR_W  free fail reason
- rsp_valid  out  1  merged response valid
- rsp_ready  in  1  host accepts response
- rsp_type  out  1  0 = alloc, 1 = free
- rsp_id  out  ID_W  response id
- rsp_page_idx  out  IDX_W  page index; 0 for free responses
- rsp_fail  out  1  fail flag
- rsp_fail_reason  out  FR_W  fail reason
- alloc_afull, free_afull  out  1 each  channel FIFO occupancy ≥ AFULL_LVL
- alloc_ovf, free_ovf  out  1 each  sticky: a strobe arrived with that FIFO full
- ovf_clr  in  1  clears both sticky overflow flags

## Operation
- Each channel: FIFO of DEPTH entries, occupancy counter of width PTR_W+1. Alloc entry = {id, page_idx, fail, reason}; free entry = {id, fail, reason}.
- Write: strobe high at a rising edge pushes one entry. If the FIFO is full and is not popped in that cycle, the entry is dropped and the channel's `_ovf` flag sets. If the FIFO is full and popped in the same cycle, the write is accepted and occupancy is unchanged.
- Output register: one entry holding rsp_* and rsp_valid. It loads when `!rsp_valid || rsp_ready`.
- Arbitration, evaluated when the output register loads:
  - Exactly one FIFO non-empty: pop that FIFO.
  - Both non-empty: round-robin. Grant the channel not granted last. The `last_grant` flop resets to free, so alloc wins the first tie.
  - Neither non-empty: rsp_valid clears on handshake.
- rsp_page_idx is forced to 0 when a free response loads.
- ovf_clr: clears flags at the edge. If an overflow occurs in the same cycle as ovf_clr, the set wins.
- Reset values:
  - rsp_valid, rsp_type, rsp_id, rsp_page_idx, rsp_fail, rsp_fail_reason: 0.
  - afull and ovf outputs: 0.
  - FIFOs empty; last_grant = free.
- Reset mid-operation flushes all buffered and held responses with no output.

## Timing
- Latency: a strobe sampled at edge k, into an empty block, gives rsp_valid high after edge k+1.
- Throughput: one response per cycle with rsp_ready held high. Both channels strobing every cycle saturate the output and the FIFOs fill at 1 entry per 2 cycles each.
- Output stability: while `rsp_valid && !rsp_ready`, all rsp_* hold stable.
- afull and ovf are registered from post-edge occupancy. afull changes in the cycle after occupancy crosses AFULL_LVL.
- No combinational path from rsp_ready to rsp_valid or rsp_* data. rsp_ready only gates the pop and the register load.

## Structure
- Widths come from the shared header mmu_param.vh (REQ_ID_WIDTH, ALL_PAGE_IDX_WIDTH, FAIL_REASON_WIDTH). Add RSP_TYPE_ALLOC = 1'b0 and RSP_TYPE_FREE = 1'b1 there.
- One sub-module: mmu_rsp_fifo. It is a register-array FIFO, parameterised WIDTH/DEPTH/PTR_W, with fall-through read data, push/pop, full/empty and count. It is instantiated twice: alloc width ID_W+IDX_W+1+FR_W, free width ID_W+1+FR_W.
- Arbiter, output register and overflow flags live in the top module.

## Test plan
- Single alloc: one strobe with id=5, page_idx=0x0A8, fail=0, rsp_ready=1. Expect rsp_valid for exactly 1 cycle, 2 edges after the strobe, with type=0, id=5, page_idx=0x0A8.
- Simultaneous: alloc id=1 and free id=2 in the same cycle, ready=1. Expect alloc id=1 then free id=2 on consecutive cycles. Repeat the pair and expect the order to stay alternating.
- Back-pressure: ready=0, 3 alloc strobes (ids 10, 11, 12). Expect rsp_valid held with id=10 stable. Raise ready and expect 10, 11, 12 in order, then rsp_valid low.
- Overflow: ready=0, 10 free strobes (ids 0–9), DEPTH=8. Expect:
  - free_afull high after the 6th entry.
  - free_ovf set by the 10th strobe: with ids 0–8 retained (8 in the FIFO plus 1 in the output register), the 10th is the only one that finds the FIFO full.
  - On drain: ids 0–8 only.
  - ovf_clr clears free_ovf.
- Full plus pop: FIFO full, ready=1, strobe in the same cycle. Expect no overflow and the entry delivered in order.
- Reset mid-burst: assert rst_n low while 4 entries are buffered. Expect every output 0 immediately (asynchronously), and no stale response after release.

Source files
------------

// File: rtl/mmu_rsp_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmu_rsp_arbiter_pkg
// Description : Shared widths and encodings for the MMU response path.
//               The width constants mirror the MMU core's shared width set
//               (request id, page index in 512 B units, fail reason).
// Revision    : 1.0 - initial release
// ============================================================================
package mmu_rsp_arbiter_pkg;

  localparam int REQ_ID_WIDTH       = 8;
  localparam int ALL_PAGE_IDX_WIDTH = 12;
  localparam int FAIL_REASON_WIDTH  = 2;

  // Response type encoding on rsp_type.
  localparam logic RSP_TYPE_ALLOC = 1'b0;
  localparam logic RSP_TYPE_FREE  = 1'b1;

  // Channel that won the most recent arbitration.
  typedef enum logic {
    GRANT_ALLOC = 1'b0,
    GRANT_FREE  = 1'b1
  } grant_e;

endpackage
`default_nettype wire

// File: rtl/mmu_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mmu_rsp_fifo
// Description : Register-array FIFO with fall-through read data.
//               A push while full is accepted only when a pop happens in the
//               same cycle; otherwise it is ignored (the caller flags it).
// Ports       : clk, rst_n (async, active-low)
//               push/wdata  - write one entry
//               pop/rdata   - rdata is the head entry, valid while !empty
//               full, empty, count - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module mmu_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mmu_rsp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mmu_rsp_arbiter
// Description : Buffers the MMU core's alloc/free response strobes in two
//               FIFOs and merges them round-robin into one valid/ready
//               response stream. Drops on a full FIFO set a sticky flag.
// Ports       : clk, rst_n (async, active-low)
//               alloc_rsp_* / free_rsp_* - fire-and-forget response strobes
//               rsp_valid/rsp_ready, rsp_*  - merged registered output
//               *_afull - occupancy >= AFULL_LVL; *_ovf - sticky drop flags
//               ovf_clr - clears both overflow flags (a new drop wins)
// Revision    : 1.0 - initial release
// ============================================================================
module mmu_rsp_arbiter
  import mmu_rsp_arbiter_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int PTR_W     = 3,
  parameter int ID_W      = REQ_ID_WIDTH,
  parameter int IDX_W     = ALL_PAGE_IDX_WIDTH,
  parameter int FR_W      = FAIL_REASON_WIDTH,
  parameter int AFULL_LVL = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_rsp_write_en,
  input  logic [ID_W-1:0]  alloc_rsp_id,
  input  logic [IDX_W-1:0] alloc_rsp_page_idx,
  input  logic             alloc_rsp_fail,
  input  logic [FR_W-1:0]  alloc_rsp_fail_reason,
  input  logic             free_rsp_write_en,
  input  logic [ID_W-1:0]  free_rsp_id,
  input  logic             free_rsp_fail,
  input  logic [FR_W-1:0]  free_rsp_fail_reason,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_type,
  output logic [ID_W-1:0]  rsp_id,
  output logic [IDX_W-1:0] rsp_page_idx,
  output logic             rsp_fail,
  output logic [FR_W-1:0]  rsp_fail_reason,
  output logic             alloc_afull,
  output logic             free_afull,
  output logic             alloc_ovf,
  output logic             free_ovf,
  input  logic             ovf_clr
);

  localparam int              AW        = ID_W + IDX_W + 1 + FR_W;
  localparam int              FW        = ID_W + 1 + FR_W;
  localparam logic [PTR_W:0]  AFULL_CNT = AFULL_LVL[PTR_W:0];

  logic [AW-1:0]    alloc_wdata, alloc_rdata;
  logic [FW-1:0]    free_wdata, free_rdata;
  logic             alloc_full, alloc_empty, free_full, free_empty;
  logic [PTR_W:0]   alloc_count, free_count;
  logic [PTR_W:0]   alloc_cnt_next, free_cnt_next;
  logic             alloc_pop, free_pop;
  logic             alloc_push_ok, free_push_ok;
  logic             alloc_drop, free_drop;
  logic             load, grant_alloc, grant_free;
  grant_e           last_grant;

  logic [ID_W-1:0]  a_id, f_id;
  logic [IDX_W-1:0] a_page;
  logic             a_fail, f_fail;
  logic [FR_W-1:0]  a_reason, f_reason;

  assign alloc_wdata = {alloc_rsp_id, alloc_rsp_page_idx, alloc_rsp_fail, alloc_rsp_fail_reason};
  assign free_wdata  = {free_rsp_id, free_rsp_fail, free_rsp_fail_reason};
  assign {a_id, a_page, a_fail, a_reason} = alloc_rdata;
  assign {f_id, f_fail, f_reason}         = free_rdata;

  mmu_rsp_fifo #(.WIDTH(AW), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_alloc_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (alloc_rsp_write_en),
    .wdata (alloc_wdata),
    .pop   (alloc_pop),
    .rdata (alloc_rdata),
    .full  (alloc_full),
    .empty (alloc_empty),
    .count (alloc_count)
  );

  mmu_rsp_fifo #(.WIDTH(FW), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_free_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (free_rsp_write_en),
    .wdata (free_wdata),
    .pop   (free_pop),
    .rdata (free_rdata),
    .full  (free_full),
    .empty (free_empty),
    .count (free_count)
  );

  // rsp_ready only qualifies the load; it never reaches rsp_* combinationally.
  assign load = !rsp_valid || rsp_ready;

  // On a tie the channel that did not win last time gets the slot.
  always_comb begin
    grant_alloc = !alloc_empty && (free_empty || (last_grant == GRANT_FREE));
    grant_free  = !free_empty && !grant_alloc;
  end

  assign alloc_pop = load && grant_alloc;
  assign free_pop  = load && grant_free;

  // Post-edge occupancy, so afull is registered in step with the FIFO count.
  assign alloc_push_ok  = alloc_rsp_write_en && (!alloc_full || alloc_pop);
  assign free_push_ok   = free_rsp_write_en && (!free_full || free_pop);
  assign alloc_cnt_next = alloc_count + {{PTR_W{1'b0}}, alloc_push_ok} - {{PTR_W{1'b0}}, alloc_pop};
  assign free_cnt_next  = free_count + {{PTR_W{1'b0}}, free_push_ok} - {{PTR_W{1'b0}}, free_pop};
  assign alloc_drop     = alloc_rsp_write_en && alloc_full && !alloc_pop;
  assign free_drop      = free_rsp_write_en && free_full && !free_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid       <= 1'b0;
      rsp_type        <= RSP_TYPE_ALLOC;
      rsp_id          <= '0;
      rsp_page_idx    <= '0;
      rsp_fail        <= 1'b0;
      rsp_fail_reason <= '0;
      last_grant      <= GRANT_FREE;
    end else if (load) begin
      if (grant_alloc) begin
        rsp_valid       <= 1'b1;
        rsp_type        <= RSP_TYPE_ALLOC;
        rsp_id          <= a_id;
        rsp_page_idx    <= a_page;
        rsp_fail        <= a_fail;
        rsp_fail_reason <= a_reason;
        last_grant      <= GRANT_ALLOC;
      end else if (grant_free) begin
        rsp_valid       <= 1'b1;
        rsp_type        <= RSP_TYPE_FREE;
        rsp_id          <= f_id;
        rsp_page_idx    <= '0;
        rsp_fail        <= f_fail;
        rsp_fail_reason <= f_reason;
        last_grant      <= GRANT_FREE;
      end else begin
        rsp_valid       <= 1'b0;
      end
    end
  end

  // A drop in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_afull <= 1'b0;
      free_afull  <= 1'b0;
      alloc_ovf   <= 1'b0;
      free_ovf    <= 1'b0;
    end else begin
      alloc_afull <= (alloc_cnt_next >= AFULL_CNT);
      free_afull  <= (free_cnt_next >= AFULL_CNT);
      if (alloc_drop)   alloc_ovf <= 1'b1;
      else if (ovf_clr) alloc_ovf <= 1'b0;
      if (free_drop)    free_ovf  <= 1'b1;
      else if (ovf_clr) free_ovf  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmu_rsp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmu_rsp_arbiter
// Description : Scoreboard bench for mmu_rsp_arbiter. Stimulus pushes the
//               expected responses in delivery order; a monitor pops and
//               compares on every rsp_valid && rsp_ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmu_rsp_arbiter;
  import mmu_rsp_arbiter_pkg::*;

  typedef struct packed {
    logic                          typ;
    logic [REQ_ID_WIDTH-1:0]       id;
    logic [ALL_PAGE_IDX_WIDTH-1:0] page;
    logic                          fail;
    logic [FAIL_REASON_WIDTH-1:0]  reason;
  } rsp_t;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          alloc_rsp_write_en;
  logic [REQ_ID_WIDTH-1:0]       alloc_rsp_id;
  logic [ALL_PAGE_IDX_WIDTH-1:0] alloc_rsp_page_idx;
  logic                          alloc_rsp_fail;
  logic [FAIL_REASON_WIDTH-1:0]  alloc_rsp_fail_reason;
  logic                          free_rsp_write_en;
  logic [REQ_ID_WIDTH-1:0]       free_rsp_id;
  logic                          free_rsp_fail;
  logic [FAIL_REASON_WIDTH-1:0]  free_rsp_fail_reason;
  logic                          rsp_valid;
  logic                          rsp_ready;
  logic                          rsp_type;
  logic [REQ_ID_WIDTH-1:0]       rsp_id;
  logic [ALL_PAGE_IDX_WIDTH-1:0] rsp_page_idx;
  logic                          rsp_fail;
  logic [FAIL_REASON_WIDTH-1:0]  rsp_fail_reason;
  logic                          alloc_afull, free_afull, alloc_ovf, free_ovf;
  logic                          ovf_clr;

  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];

  mmu_rsp_arbiter dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .alloc_rsp_write_en    (alloc_rsp_write_en),
    .alloc_rsp_id          (alloc_rsp_id),
    .alloc_rsp_page_idx    (alloc_rsp_page_idx),
    .alloc_rsp_fail        (alloc_rsp_fail),
    .alloc_rsp_fail_reason (alloc_rsp_fail_reason),
    .free_rsp_write_en     (free_rsp_write_en),
    .free_rsp_id           (free_rsp_id),
    .free_rsp_fail         (free_rsp_fail),
    .free_rsp_fail_reason  (free_rsp_fail_reason),
    .rsp_valid             (rsp_valid),
    .rsp_ready             (rsp_ready),
    .rsp_type              (rsp_type),
    .rsp_id                (rsp_id),
    .rsp_page_idx          (rsp_page_idx),
    .rsp_fail              (rsp_fail),
    .rsp_fail_reason       (rsp_fail_reason),
    .alloc_afull           (alloc_afull),
    .free_afull            (free_afull),
    .alloc_ovf             (alloc_ovf),
    .free_ovf              (free_ovf),
    .ovf_clr               (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual id=%0h type=%0b expected none", rsp_id, rsp_type);
      end else begin
        rsp_t e;
        rsp_t a;
        e = exp_q.pop_front();
        a = '{typ: rsp_type, id: rsp_id, page: rsp_page_idx, fail: rsp_fail, reason: rsp_fail_reason};
        check("rsp_data", 32'(a), 32'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_alloc(input logic en, input int id, input int page, input logic fail, input int rsn);
    alloc_rsp_write_en    = en;
    alloc_rsp_id          = REQ_ID_WIDTH'(id);
    alloc_rsp_page_idx    = ALL_PAGE_IDX_WIDTH'(page);
    alloc_rsp_fail        = fail;
    alloc_rsp_fail_reason = FAIL_REASON_WIDTH'(rsn);
  endtask

  task automatic set_free(input logic en, input int id, input logic fail, input int rsn);
    free_rsp_write_en    = en;
    free_rsp_id          = REQ_ID_WIDTH'(id);
    free_rsp_fail        = fail;
    free_rsp_fail_reason = FAIL_REASON_WIDTH'(rsn);
  endtask

  function automatic rsp_t mk(input logic typ, input int id, input int page, input logic fail, input int rsn);
    mk = '{typ: typ, id: REQ_ID_WIDTH'(id), page: ALL_PAGE_IDX_WIDTH'(page),
           fail: fail, reason: FAIL_REASON_WIDTH'(rsn)};
  endfunction

  // Bounded wait for the scoreboard to empty, then confirm the output idles.
  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    tick();
    check({name, "_idle"}, rsp_valid, 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, rsp_valid, 0);
    check({name, "_data"}, {rsp_type, rsp_id, rsp_page_idx, rsp_fail, rsp_fail_reason}, 0);
    check({name, "_flags"}, {alloc_afull, free_afull, alloc_ovf, free_ovf}, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    ovf_clr   = 1'b0;
    set_alloc(0, 0, 0, 0, 0);
    set_free(0, 0, 0, 0);
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single alloc: valid for exactly one cycle, two edges after the strobe.
    rsp_ready = 1'b1;
    set_alloc(1, 5, 'h0A8, 0, 0);
    exp_q.push_back(mk(RSP_TYPE_ALLOC, 5, 'h0A8, 0, 0));
    tick();
    set_alloc(0, 0, 0, 0, 0);
    check("single_edge_k", rsp_valid, 0);
    tick();
    check("single_edge_k1", rsp_valid, 1);
    tick();
    check("single_edge_k2", rsp_valid, 0);

    // Simultaneous pairs: alloc wins the first tie, then strict alternation.
    do_reset();
    set_alloc(1, 1, 'h011, 0, 0);
    set_free(1, 2, 1, 2);
    exp_q.push_back(mk(RSP_TYPE_ALLOC, 1, 'h011, 0, 0));
    exp_q.push_back(mk(RSP_TYPE_FREE, 2, 0, 1, 2));
    tick();
    set_alloc(1, 3, 'h033, 1, 3);
    set_free(1, 4, 0, 1);
    exp_q.push_back(mk(RSP_TYPE_ALLOC, 3, 'h033, 1, 3));
    exp_q.push_back(mk(RSP_TYPE_FREE, 4, 0, 0, 1));
    tick();
    set_alloc(0, 0, 0, 0, 0);
    set_free(0, 0, 0, 0);
    drain("pair");

    // Back-pressure: head response holds stable until accepted.
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_alloc(1, 10 + i, 'h100 + i, 0, 0);
      exp_q.push_back(mk(RSP_TYPE_ALLOC, 10 + i, 'h100 + i, 0, 0));
      tick();
    end
    set_alloc(0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_id", rsp_id, 10);
    end
    rsp_ready = 1'b1;
    drain("bp");

    // Overflow: ids 0..8 retained, id 9 dropped; afull from the 6th FIFO entry.
    do_reset();
    rsp_ready = 1'b0;
    for (int j = 0; j < 10; j++) begin
      set_free(1, j, 0, j);
      if (j <= 8) exp_q.push_back(mk(RSP_TYPE_FREE, j, 0, 0, j));
      tick();
      check($sformatf("ovf_afull_%0d", j), free_afull, (j >= 6));
      check($sformatf("ovf_flag_%0d", j), free_ovf, (j == 9));
    end
    set_free(0, 0, 0, 0);
    tick();
    check("ovf_sticky", free_ovf, 1);
    check("ovf_alloc_clean", alloc_ovf, 0);
    rsp_ready = 1'b1;
    drain("ovf");
    check("ovf_afull_drained", free_afull, 0);
    check("ovf_before_clr", free_ovf, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", free_ovf, 0);

    // Full FIFO popped and pushed in the same cycle: no drop.
    do_reset();
    rsp_ready = 1'b0;
    for (int j = 0; j < 9; j++) begin
      set_alloc(1, 20 + j, 'h200 + j, 0, 1);
      exp_q.push_back(mk(RSP_TYPE_ALLOC, 20 + j, 'h200 + j, 0, 1));
      tick();
    end
    check("full_afull", alloc_afull, 1);
    rsp_ready = 1'b1;
    set_alloc(1, 29, 'h229, 1, 2);
    exp_q.push_back(mk(RSP_TYPE_ALLOC, 29, 'h229, 1, 2));
    tick();
    set_alloc(0, 0, 0, 0, 0);
    check("full_pop_no_ovf", alloc_ovf, 0);
    drain("fullpop");

    // Reset mid-burst: asynchronous clear, nothing stale afterwards.
    rsp_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      set_alloc(1, 40 + j, 'h300 + j, 0, 0);
      tick();
    end
    set_alloc(0, 0, 0, 0, 0);
    check("midrst_pre_valid", rsp_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("midrst_no_stale", rsp_valid, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
